burst_bus_arbiter: RTL and testbench
====================================

Name: burst_bus_arbiter

Overview:
- Shares one burst memory controller port between two requesters.
- Port 0 is the video framebuffer reader: high priority, read-only.
- Port 1 is a general-purpose read/write master, e.g. a debug-bus DMA or blitter.
- Sequences one command at a time, forwards write beats, routes read beats back to the issuing port, and bounds port 1 starvation.

Parameters:
- BURST_BEATS, 4, number of 64-bit data beats per read or write command.
- CMD_GAP, 2, idle cycles enforced after each completed command before the next grant.
- READ_TIMEOUT, 64, cycles without a read beat before an outstanding read is abandoned.
- MAX_P0_STREAK, 3, consecutive port 0 grants allowed while port 1 waits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- p0_cmd_en  in  1  port 0 read request, held until acked
- p0_addr  in  21  port 0 word address
- p0_cmd_ack  out  1  one-cycle pulse, port 0 command accepted
- p0_rd_data  out  64  read beat to port 0
- p0_rd_data_valid  out  1  read beat valid for port 0
- p1_cmd_en  in  1  port 1 request, held until acked
- p1_cmd  in  1  port 1 command: 0 = read, 1 = write
- p1_addr  in  21  port 1 word address
- p1_wr_data  in  64  port 1 write beat
- p1_data_mask  in  8  port 1 byte mask, 1 = masked
- p1_cmd_ack  out  1  one-cycle pulse, port 1 command accepted
- p1_wr_next  out  1  port 1 must present the next write beat in the following cycle
- p1_rd_data  out  64  read beat to port 1
- p1_rd_data_valid  out  1  read beat valid for port 1
- mem_cmd_en  out  1  command strobe to the memory controller
- mem_cmd  out  1  0 = read, 1 = write
- mem_addr  out  21  command address
- mem_wr_data  out  64  write beat
- mem_data_mask  out  8  write byte mask
- mem_rd_data  in  64  read beat from the controller
- mem_rd_data_valid  in  1  read beat valid
- timeout_err  out  1  one-cycle pulse when a read is abandoned

Behaviour:
- Reset (synchronous, active-high): state IDLE; all counters 0; streak 0. All outputs 0, including mem_wr_data, mem_data_mask and both rd_data buses.
- States: IDLE, READ_WAIT, WRITE_DATA, GAP.
- IDLE grant rule:
  - Port 1 wins if p1_cmd_en is set and (p0_cmd_en is low or streak == MAX_P0_STREAK).
  - Otherwise port 0 wins if p0_cmd_en is set.
- Grant cycle:
  - mem_cmd_en = 1; mem_cmd and mem_addr come combinationally from the winner.
  - The winner's cmd_ack = 1 in the same cycle.
  - Grant latency from request to ack is 0 cycles when IDLE and not blocked.
- Streak counter:
  - Increments on a port 0 grant while p1_cmd_en is set, saturating at MAX_P0_STREAK.
  - Clears on any port 1 grant, and on a port 0 grant while p1_cmd_en is low.
- Read grant:
  - Latch owner; go to READ_WAIT; beat count = 0; timer = 0.
- Write grant (port 1 only):
  - mem_wr_data and mem_data_mask carry beat 0 in the grant cycle.
  - Go to WRITE_DATA for BURST_BEATS-1 further cycles; mem_wr_data and mem_data_mask pass through from p1 each cycle.
  - p1_wr_next is high in the grant cycle and in every WRITE_DATA cycle except the last.
- READ_WAIT:
  - Each mem_rd_data_valid is forwarded combinationally (same cycle) to the owner's rd_data/rd_data_valid; increment beat count and clear timer.
  - The non-owner's rd_data_valid is 0.
  - After beat BURST_BEATS, go to GAP.
  - If the timer reaches READ_TIMEOUT, pulse timeout_err and go to GAP.
- Late or unexpected beats: mem_rd_data_valid outside READ_WAIT is dropped; neither port sees it.
- GAP: count CMD_GAP cycles, then IDLE. With CMD_GAP = 0, GAP lasts 0 cycles and returns straight to IDLE.
- Command issue: mem_cmd_en is asserted only in the grant cycle, never in READ_WAIT, WRITE_DATA or GAP.
- Request withdrawal: a request dropped before ack is simply not granted, with no side effects.
- Reset mid-burst: abandons the burst immediately; no ack or valid in the reset cycle.
- Width rules: beat counter width is $clog2(BURST_BEATS+1); timer width is $clog2(READ_TIMEOUT+1). Addresses pass through unmodified.

Decomposition:
- Package burst_arb_pkg:
  - typedef enum arb_state_e {IDLE, READ_WAIT, WRITE_DATA, GAP}
  - constants CMD_READ = 0, CMD_WRITE = 1
  - typedef arb_owner_e {OWNER_P0, OWNER_P1}
- One sub-module, burst_arb_grant: the combinational priority/streak decision plus the streak register. Owns the fairness rule so it can be tested alone.
- FSM, counters and data muxing stay in the top module.

Test Plan:
- Port 0 read alone: p0 request at addr 0x100 -> ack and mem_cmd_en in the same cycle, mem_cmd = 0. Four mem beats 0xA..0xD appear on p0_rd_data in the same cycles. The next grant is possible no earlier than 2 cycles after the last beat.
- Port 1 write: p1 write to addr 0x40 with data 1, 2, 3, 4 -> mem_cmd = 1. mem_wr_data shows 1, 2, 3, 4 on 4 consecutive cycles starting at the grant. p1_wr_next is high for exactly 3 cycles.
- Contention: p0 and p1 requesting continuously -> grant order p0, p0, p0, p1, p0, p0, p0, p1. p1_rd_data_valid is never asserted during p0 reads.
- Timeout: p0 read, controller returns 2 beats then stops -> timeout_err pulses 64 cycles after the second beat. The arbiter then returns to IDLE after the gap, and a subsequent p1 read completes normally.
- Stray beat: mem_rd_data_valid asserted in IDLE -> neither rd_data_valid asserts.
- Reset during WRITE_DATA after beat 1 -> the next cycle shows IDLE with all outputs 0; a fresh p0 request is acked immediately.

Source files
------------

// File: rtl/burst_arb_pkg.sv
// Shared types for the burst bus arbiter.
//   arb_state_e : sequencing state of the shared memory port
//   arb_owner_e : which requester owns the outstanding read
//   CMD_READ / CMD_WRITE : encoding of the mem_cmd / p1_cmd bit
package burst_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_DATA,
    GAP
  } arb_state_e;

  typedef enum logic {
    OWNER_P0,
    OWNER_P1
  } arb_owner_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_arb_grant.sv
// Priority decision between the two requesters plus the port 0 streak count.
// Port 0 normally wins; once it has been granted MAX_P0_STREAK times in a row
// while port 1 was waiting, port 1 is given the next slot.
//   clk, reset : clock and synchronous active-high reset
//   grant_en   : arbiter is idle and may issue a grant this cycle
//   p0_req     : port 0 request
//   p1_req     : port 1 request
//   grant_p0   : port 0 is granted this cycle
//   grant_p1   : port 1 is granted this cycle
module burst_arb_grant
  import burst_arb_pkg::*;
#(
  parameter int MAX_P0_STREAK = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
  input  logic p0_req,
  input  logic p1_req,
  output logic grant_p0,
  output logic grant_p1
);

  localparam int SW = (MAX_P0_STREAK > 0) ? $clog2(MAX_P0_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_P0_STREAK);

  logic [SW-1:0] streak;

  always_comb begin
    grant_p1 = grant_en && p1_req && (!p0_req || (streak == STREAK_MAX));
    grant_p0 = grant_en && p0_req && !grant_p1;
  end

  // Streak only grows while port 1 is actually being held off.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (grant_p1) begin
      streak <= '0;
    end else if (grant_p0) begin
      if (!p1_req) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + SW'(1);
      end
    end
  end

endmodule

// File: rtl/burst_bus_arbiter.sv
// Shares one burst memory controller port between a high-priority read-only
// video reader (port 0) and a general read/write master (port 1). One command
// is in flight at a time; writes stream from port 1, read beats are steered
// back to the issuing port, stalled reads are abandoned after READ_TIMEOUT.
//   clk, reset          : clock, synchronous active-high reset
//   p0_cmd_en/addr      : port 0 read request (held until p0_cmd_ack)
//   p0_rd_data(_valid)  : read beats returned to port 0
//   p1_cmd_en/cmd/addr  : port 1 request (held until p1_cmd_ack)
//   p1_wr_data/mask     : port 1 write beat; p1_wr_next asks for the next one
//   p1_rd_data(_valid)  : read beats returned to port 1
//   mem_*               : command, write data and read data of the controller
//   timeout_err         : one-cycle pulse when a read is abandoned
module burst_bus_arbiter
  import burst_arb_pkg::*;
#(
  parameter int BURST_BEATS   = 4,
  parameter int CMD_GAP       = 2,
  parameter int READ_TIMEOUT  = 64,
  parameter int MAX_P0_STREAK = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_cmd_en,
  input  logic [20:0] p0_addr,
  output logic        p0_cmd_ack,
  output logic [63:0] p0_rd_data,
  output logic        p0_rd_data_valid,
  input  logic        p1_cmd_en,
  input  logic        p1_cmd,
  input  logic [20:0] p1_addr,
  input  logic [63:0] p1_wr_data,
  input  logic [7:0]  p1_data_mask,
  output logic        p1_cmd_ack,
  output logic        p1_wr_next,
  output logic [63:0] p1_rd_data,
  output logic        p1_rd_data_valid,
  output logic        mem_cmd_en,
  output logic        mem_cmd,
  output logic [20:0] mem_addr,
  output logic [63:0] mem_wr_data,
  output logic [7:0]  mem_data_mask,
  input  logic [63:0] mem_rd_data,
  input  logic        mem_rd_data_valid,
  output logic        timeout_err
);

  localparam int BW = $clog2(BURST_BEATS + 1);
  localparam int TW = $clog2(READ_TIMEOUT + 1);
  localparam int GW = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
  // With no gap configured a finished command drops straight back to IDLE.
  localparam arb_state_e DONE_STATE = arb_state_e'((CMD_GAP == 0) ? IDLE : GAP);

  arb_state_e    state, state_next;
  arb_owner_e    owner, owner_next;
  logic [BW-1:0] beat_cnt, beat_next;
  logic [TW-1:0] timer, timer_next;
  logic [GW-1:0] gap_cnt, gap_next;
  logic          grant_p0, grant_p1;

  burst_arb_grant #(
    .MAX_P0_STREAK(MAX_P0_STREAK)
  ) u_grant (
    .clk     (clk),
    .reset   (reset),
    .grant_en((state == IDLE) && !reset),
    .p0_req  (p0_cmd_en),
    .p1_req  (p1_cmd_en),
    .grant_p0(grant_p0),
    .grant_p1(grant_p1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= OWNER_P0;
      beat_cnt <= '0;
      timer    <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      beat_cnt <= beat_next;
      timer    <= timer_next;
      gap_cnt  <= gap_next;
    end
  end

  // All outputs are combinational and forced quiet while reset is high, so a
  // reset cycle never shows an ack or a valid beat.
  always_comb begin
    state_next       = state;
    owner_next       = owner;
    beat_next        = beat_cnt;
    timer_next       = timer;
    gap_next         = gap_cnt;
    p0_cmd_ack       = 1'b0;
    p0_rd_data       = '0;
    p0_rd_data_valid = 1'b0;
    p1_cmd_ack       = 1'b0;
    p1_wr_next       = 1'b0;
    p1_rd_data       = '0;
    p1_rd_data_valid = 1'b0;
    mem_cmd_en       = 1'b0;
    mem_cmd          = CMD_READ;
    mem_addr         = '0;
    mem_wr_data      = '0;
    mem_data_mask    = '0;
    timeout_err      = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (grant_p1) begin
            mem_cmd_en = 1'b1;
            mem_cmd    = p1_cmd;
            mem_addr   = p1_addr;
            p1_cmd_ack = 1'b1;
            owner_next = OWNER_P1;
            if (p1_cmd == CMD_WRITE) begin
              // Beat 0 rides along with the command.
              mem_wr_data   = p1_wr_data;
              mem_data_mask = p1_data_mask;
              if (BURST_BEATS > 1) begin
                p1_wr_next = 1'b1;
                state_next = WRITE_DATA;
                beat_next  = BW'(1);
              end else begin
                state_next = DONE_STATE;
              end
            end else begin
              state_next = READ_WAIT;
              beat_next  = '0;
              timer_next = '0;
            end
          end else if (grant_p0) begin
            mem_cmd_en = 1'b1;
            mem_cmd    = CMD_READ;
            mem_addr   = p0_addr;
            p0_cmd_ack = 1'b1;
            owner_next = OWNER_P0;
            state_next = READ_WAIT;
            beat_next  = '0;
            timer_next = '0;
          end
        end
        READ_WAIT: begin
          if (mem_rd_data_valid) begin
            if (owner == OWNER_P0) begin
              p0_rd_data       = mem_rd_data;
              p0_rd_data_valid = 1'b1;
            end else begin
              p1_rd_data       = mem_rd_data;
              p1_rd_data_valid = 1'b1;
            end
            beat_next  = beat_cnt + BW'(1);
            timer_next = '0;
            if (beat_cnt == BW'(BURST_BEATS - 1)) begin
              state_next = DONE_STATE;
            end
          end else if (timer == TW'(READ_TIMEOUT - 1)) begin
            // This idle cycle is the READ_TIMEOUT-th without a beat.
            timeout_err = 1'b1;
            timer_next  = '0;
            state_next  = DONE_STATE;
          end else begin
            timer_next = timer + TW'(1);
          end
        end
        WRITE_DATA: begin
          mem_wr_data   = p1_wr_data;
          mem_data_mask = p1_data_mask;
          if (beat_cnt == BW'(BURST_BEATS - 1)) begin
            beat_next  = '0;
            state_next = DONE_STATE;
          end else begin
            p1_wr_next = 1'b1;
            beat_next  = beat_cnt + BW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GW'(CMD_GAP - 1)) begin
            gap_next   = '0;
            state_next = IDLE;
          end else begin
            gap_next = gap_cnt + GW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_bus_arbiter.sv
// Self-checking bench for burst_bus_arbiter. A timestamp-based reference
// model predicts every output each cycle; directed scenarios are followed by
// a randomized phase with random requests, beat spacing and stray beats.
module tb_burst_bus_arbiter;

  localparam int BEATS = 4;
  localparam int GAPC  = 2;
  localparam int TMO   = 64;
  localparam int MAXS  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_cmd_en;
  logic [20:0] p0_addr;
  logic        p0_cmd_ack;
  logic [63:0] p0_rd_data;
  logic        p0_rd_data_valid;
  logic        p1_cmd_en;
  logic        p1_cmd;
  logic [20:0] p1_addr;
  logic [63:0] p1_wr_data;
  logic [7:0]  p1_data_mask;
  logic        p1_cmd_ack;
  logic        p1_wr_next;
  logic [63:0] p1_rd_data;
  logic        p1_rd_data_valid;
  logic        mem_cmd_en;
  logic        mem_cmd;
  logic [20:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_data_mask;
  logic [63:0] mem_rd_data;
  logic        mem_rd_data_valid;
  logic        timeout_err;

  always #5 clk = ~clk;

  burst_bus_arbiter #(
    .BURST_BEATS(BEATS), .CMD_GAP(GAPC), .READ_TIMEOUT(TMO), .MAX_P0_STREAK(MAXS)
  ) dut (
    .clk(clk), .reset(reset),
    .p0_cmd_en(p0_cmd_en), .p0_addr(p0_addr), .p0_cmd_ack(p0_cmd_ack),
    .p0_rd_data(p0_rd_data), .p0_rd_data_valid(p0_rd_data_valid),
    .p1_cmd_en(p1_cmd_en), .p1_cmd(p1_cmd), .p1_addr(p1_addr),
    .p1_wr_data(p1_wr_data), .p1_data_mask(p1_data_mask),
    .p1_cmd_ack(p1_cmd_ack), .p1_wr_next(p1_wr_next),
    .p1_rd_data(p1_rd_data), .p1_rd_data_valid(p1_rd_data_valid),
    .mem_cmd_en(mem_cmd_en), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask),
    .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: the port is free from cycle m_free onward unless a read
  // or write transaction is open; transactions are tracked by timestamps.
  bit m_rd = 0, m_wr = 0;
  int m_owner = 0, m_beats = 0, m_last = 0, m_free = 0, m_streak = 0;
  int m_wg = 0, m_next_beat = 0;

  // Memory responder and write-source settings.
  int          resp_limit = BEATS;
  bit          rand_gap   = 0;
  bit          rand_data  = 0;
  logic [63:0] beat_base  = 64'h0;
  logic [63:0] wq[4];
  logic [7:0]  mq[4];

  // Observation logs.
  int          gport[$];
  int          gcyc[$];
  logic [63:0] p0_seen[$];
  logic [63:0] wr_seen[$];
  int          wstart = -100;
  int          wrnext_cnt = 0;
  int          p1_cnt = 0;
  int          last_p0_beat = 0;
  int          to_cyc = -1;

  function automatic int dly();
    return rand_gap ? int'($urandom_range(0, 3)) : 0;
  endfunction

  task automatic chk(string tag, logic [228:0] obs, logic [228:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick(string tag);
    logic        e_a0, e_v0, e_a1, e_wn, e_v1, e_ce, e_c, e_to;
    logic [63:0] e_d0, e_d1, e_wd;
    logic [20:0] e_ad;
    logic [7:0]  e_m;
    bit          idle;
    int          w;
    #2;
    {e_a0, e_v0, e_a1, e_wn, e_v1, e_ce, e_c, e_to} = '0;
    e_d0 = '0; e_d1 = '0; e_wd = '0; e_ad = '0; e_m = '0;
    w    = 0;
    idle = (cyc >= m_free) && !m_rd && !m_wr;
    if (reset) begin
      m_rd = 0; m_wr = 0; m_streak = 0; m_free = cyc + 1;
    end else if (idle) begin
      if (p1_cmd_en && (!p0_cmd_en || m_streak == MAXS)) w = 2;
      else if (p0_cmd_en) w = 1;
      if (w == 1) begin
        e_a0 = 1; e_ce = 1; e_c = 0; e_ad = p0_addr;
        m_rd = 1; m_owner = 0; m_beats = 0; m_last = cyc; m_next_beat = cyc + 1 + dly();
        m_streak = p1_cmd_en ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (w == 2) begin
        e_a1 = 1; e_ce = 1; e_c = p1_cmd; e_ad = p1_addr;
        m_streak = 0;
        if (p1_cmd) begin
          e_wd = p1_wr_data; e_m = p1_data_mask; e_wn = 1;
          m_wr = 1; m_wg = cyc;
        end else begin
          m_rd = 1; m_owner = 1; m_beats = 0; m_last = cyc; m_next_beat = cyc + 1 + dly();
        end
      end
    end else if (m_rd) begin
      if (mem_rd_data_valid) begin
        if (m_owner == 0) begin e_v0 = 1; e_d0 = mem_rd_data; end
        else begin e_v1 = 1; e_d1 = mem_rd_data; end
        m_beats++; m_last = cyc; m_next_beat = cyc + 1 + dly();
        if (m_beats == BEATS) begin m_rd = 0; m_free = cyc + 1 + GAPC; end
      end else if (cyc - m_last == TMO) begin
        e_to = 1; m_rd = 0; m_free = cyc + 1 + GAPC;
      end
    end else if (m_wr) begin
      e_wd = p1_wr_data; e_m = p1_data_mask;
      e_wn = (cyc - m_wg) < BEATS - 1;
      if (cyc - m_wg == BEATS - 1) begin m_wr = 0; m_free = cyc + 1 + GAPC; end
    end
    chk(tag,
        {p0_cmd_ack, p0_rd_data_valid, p0_rd_data, p1_cmd_ack, p1_wr_next,
         p1_rd_data_valid, p1_rd_data, mem_cmd_en, mem_cmd, mem_addr,
         mem_wr_data, mem_data_mask, timeout_err},
        {e_a0, e_v0, e_d0, e_a1, e_wn, e_v1, e_d1, e_ce, e_c, e_ad, e_wd, e_m, e_to});
    if (p0_cmd_ack) begin gport.push_back(0); gcyc.push_back(cyc); end
    if (p1_cmd_ack) begin gport.push_back(1); gcyc.push_back(cyc); end
    if (p1_cmd_ack && mem_cmd) wstart = cyc;
    if (cyc >= wstart && cyc < wstart + BEATS) wr_seen.push_back(mem_wr_data);
    if (p1_wr_next) wrnext_cnt++;
    if (p0_rd_data_valid) begin p0_seen.push_back(p0_rd_data); last_p0_beat = cyc; end
    if (p1_rd_data_valid) p1_cnt++;
    if (timeout_err) to_cyc = cyc;
    @(negedge clk);
    cyc++;
    if (w == 1) p0_cmd_en = 0;
    if (w == 2) p1_cmd_en = 0;
    if (m_wr) begin
      p1_wr_data   = wq[cyc - m_wg];
      p1_data_mask = mq[cyc - m_wg];
    end
    if (m_rd && cyc == m_next_beat && m_beats < resp_limit) begin
      mem_rd_data_valid = 1;
      mem_rd_data       = rand_data ? {$urandom, $urandom} : beat_base + 64'(m_beats);
    end else begin
      mem_rd_data_valid = 0;
      mem_rd_data       = '0;
    end
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (!((cyc >= m_free) && !m_rd && !m_wr) && n < 200) begin
      tick(tag);
      n++;
    end
    total++;
    assert (n < 200) else begin
      bad++;
      $error("FAIL %s idle wait observed=%0d cycles required<200", tag, n);
    end
  endtask

  initial begin
    int exp_order[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int n, s0, c1, ng;
    reset = 1; p0_cmd_en = 1; p0_addr = 21'h100;
    p1_cmd_en = 0; p1_cmd = 0; p1_addr = '0; p1_wr_data = '0; p1_data_mask = '0;
    mem_rd_data = '0; mem_rd_data_valid = 0;
    beat_base = 64'hA;
    @(negedge clk);
    cyc = 0;

    // Reset with a request pending: nothing may be acked.
    tick("reset"); tick("reset");
    reset = 0;

    // Port 0 read alone, then an immediate second request to probe the gap.
    tick("p0_read");
    p0_cmd_en = 1; p0_addr = 21'h100;
    n = 0;
    while (gport.size() < 2 && n < 20) begin tick("p0_read"); n++; end
    chk("p0_first_grant_cyc", 229'(gcyc.size() > 0 ? gcyc[0] : -1), 229'(2));
    chk("p0_beat_count", 229'(p0_seen.size()), 229'(4));
    for (int i = 0; i < 4 && i < p0_seen.size(); i++)
      chk("p0_beat_data", 229'(p0_seen[i]), 229'(64'hA + 64'(i)));
    chk("p0_regrant_after_last_beat",
        229'(gcyc.size() > 1 ? gcyc[1] - last_p0_beat : -1), 229'(GAPC + 1));
    wait_idle("p0_drain");

    // Port 1 write of 1,2,3,4.
    wq = '{64'd1, 64'd2, 64'd3, 64'd4};
    mq = '{8'h00, 8'h0F, 8'hF0, 8'h81};
    wr_seen.delete(); wrnext_cnt = 0;
    p1_cmd_en = 1; p1_cmd = 1; p1_addr = 21'h40; p1_wr_data = wq[0]; p1_data_mask = mq[0];
    for (int i = 0; i < 6; i++) tick("p1_write");
    chk("wr_beat_count", 229'(wr_seen.size()), 229'(4));
    for (int i = 0; i < 4 && i < wr_seen.size(); i++)
      chk("wr_beat_data", 229'(wr_seen[i]), 229'(i + 1));
    chk("wr_next_cycles", 229'(wrnext_cnt), 229'(3));
    wait_idle("write_drain");

    // Continuous contention: fairness pattern.
    gport.delete(); gcyc.delete();
    n = 0;
    while (gport.size() < 8 && n < 300) begin
      if (!p0_cmd_en) begin p0_cmd_en = 1; p0_addr = 21'($urandom); end
      if (!p1_cmd_en) begin p1_cmd_en = 1; p1_cmd = 0; p1_addr = 21'($urandom); end
      tick("contention");
      n++;
    end
    for (int i = 0; i < 8; i++)
      chk("grant_order", 229'(i < gport.size() ? gport[i] : -1), 229'(exp_order[i]));
    p0_cmd_en = 0; p1_cmd_en = 0;
    wait_idle("contention_drain");

    // Read timeout after two beats, then a normal port 1 read.
    resp_limit = 2; to_cyc = -1;
    p0_cmd_en = 1; p0_addr = 21'h200;
    n = 0;
    while (to_cyc < 0 && n < 120) begin tick("timeout"); n++; end
    chk("timeout_delay", 229'(to_cyc - last_p0_beat), 229'(TMO));
    resp_limit = BEATS; p1_cnt = 0;
    p1_cmd_en = 1; p1_cmd = 0; p1_addr = 21'h333;
    for (int i = 0; i < 20; i++) tick("p1_read_after_timeout");
    chk("p1_read_beats", 229'(p1_cnt), 229'(BEATS));
    wait_idle("timeout_drain");

    // Stray beat while idle.
    s0 = p0_seen.size(); c1 = p1_cnt;
    mem_rd_data_valid = 1; mem_rd_data = 64'hDEAD_BEEF;
    tick("stray");
    chk("stray_p0", 229'(p0_seen.size()), 229'(s0));
    chk("stray_p1", 229'(p1_cnt), 229'(c1));

    // Reset in the middle of a write burst.
    wq = '{64'd11, 64'd22, 64'd33, 64'd44};
    mq = '{8'h00, 8'h00, 8'h00, 8'h00};
    p1_cmd_en = 1; p1_cmd = 1; p1_addr = 21'h55; p1_wr_data = wq[0]; p1_data_mask = mq[0];
    tick("rst_write_grant");
    tick("rst_write_beat1");
    reset = 1;
    tick("rst_mid_burst");
    reset = 0;
    tick("post_reset_idle");
    ng = gport.size();
    p0_cmd_en = 1; p0_addr = 21'h7;
    tick("fresh_p0");
    chk("fresh_p0_ack", 229'(gcyc.size() > ng ? gcyc[$] : -1), 229'(cyc - 1));
    wait_idle("reset_drain");

    // Randomized traffic.
    rand_gap = 1; rand_data = 1;
    for (int i = 0; i < 800; i++) begin
      if (!p0_cmd_en && $urandom_range(0, 3) == 0) begin
        p0_cmd_en = 1; p0_addr = 21'($urandom);
      end else if (p0_cmd_en && $urandom_range(0, 19) == 0) begin
        p0_cmd_en = 0;
      end
      if (!p1_cmd_en && !m_wr && $urandom_range(0, 3) == 0) begin
        p1_cmd_en = 1; p1_cmd = 1'($urandom); p1_addr = 21'($urandom);
        for (int k = 0; k < 4; k++) begin
          wq[k] = {$urandom, $urandom};
          mq[k] = 8'($urandom);
        end
        p1_wr_data = wq[0]; p1_data_mask = mq[0];
      end else if (p1_cmd_en && !m_wr && $urandom_range(0, 19) == 0) begin
        p1_cmd_en = 0;
      end
      if (!m_rd && $urandom_range(0, 9) == 0) begin
        mem_rd_data_valid = 1; mem_rd_data = {$urandom, $urandom};
      end
      tick("random");
    end
    p0_cmd_en = 0; p1_cmd_en = 0;
    wait_idle("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
